// File: rtl/instr_fetch_unit.sv
// ============================================================================
// instr_fetch_unit
// ----------------------------------------------------------------------------
// Instruction fetch front end. It issues one word fetch at a time to the
// instruction memory and queues the returned words, with their addresses, in
// a small prefetch FIFO. The core takes them from the FIFO head with a
// valid/ready handshake. A redirect from the core (branch or jump) flushes
// the FIFO and restarts fetching at the new target. Data returned for a
// request that was already in flight when the redirect arrived is dropped.
//
// Parameters
//   RESET_PC    first fetch address after reset
//   FIFO_DEPTH  prefetch buffer entries (legal range 2..8)
//
// Ports
//   clk          sole clock, everything updates on the rising edge
//   rst          synchronous active-high reset
//   mem_req      fetch request, held until mem_ack (one request in flight)
//   mem_addr     word-aligned fetch address, held with mem_req
//   mem_ack      memory response strobe, mem_rdata valid in the same cycle
//   mem_rdata    fetched instruction word
//   redirect     core branch/jump: flush the buffer and refetch
//   redirect_pc  redirect target (low two bits ignored)
//   inst_valid   instruction/inst_pc hold the FIFO head
//   instruction  head instruction word (NOP when inst_valid is low)
//   inst_pc      head instruction address (0 when inst_valid is low)
//   inst_ready   core takes the head when inst_valid && inst_ready
// ============================================================================
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        inst_valid,
    output logic [31:0] instruction,
    output logic [31:0] inst_pc,
    input  logic        inst_ready
);

    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

    localparam logic [31:0]      NOP_INSN = 32'h0000_0013;
    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(FIFO_DEPTH);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(FIFO_DEPTH - 1);

    // IDLE : no request outstanding (buffer full)
    // REQ  : request outstanding, response will be queued
    // FLUSH: request outstanding but made stale by a redirect, response dropped
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_REQ   = 2'd1,
        S_FLUSH = 2'd2
    } state_t;

    state_t            state_q,       state_d;
    logic [31:0]       fetch_pc_q,    fetch_pc_d;
    logic              mem_req_q,     mem_req_d;
    logic [31:0]       mem_addr_q,    mem_addr_d;
    logic [PTR_W-1:0]  wr_ptr_q,      wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q,      rd_ptr_d;
    logic [CNT_W-1:0]  count_q,       count_d;
    logic              inst_valid_q,  inst_valid_d;
    logic [31:0]       instruction_q, instruction_d;
    logic [31:0]       inst_pc_q,     inst_pc_d;

    // Prefetch storage: instruction word and its address per entry
    logic [31:0]       buf_instr_q [FIFO_DEPTH];
    logic [31:0]       buf_pc_q    [FIFO_DEPTH];

    logic              pop;
    logic              push;
    logic [CNT_W-1:0]  count_after_pop;

    // Pointer increment with wrap, correct for non power-of-two depths
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
    endfunction

    // ------------------------------------------------------------------------
    // Buffer handshakes and pointer/count update
    // ------------------------------------------------------------------------
    always_comb begin
        pop             = inst_valid_q && inst_ready;
        // Only a live request (REQ) delivers data; a redirect in the same
        // cycle makes the returned word stale, so it is not queued.
        push            = (state_q == S_REQ) && mem_ack && !redirect;
        count_after_pop = count_q - {{(CNT_W-1){1'b0}}, pop};

        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        if (redirect) begin
            // Flush: any same-cycle pop or push is discarded
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (pop) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end
            if (push) begin
                wr_ptr_d = ptr_inc(wr_ptr_q);
            end
            count_d = count_after_pop + {{(CNT_W-1){1'b0}}, push};
        end
    end

    // ------------------------------------------------------------------------
    // Fetch control
    // ------------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;

        // A redirect retargets fetching in every state
        if (redirect) begin
            fetch_pc_d = {redirect_pc[31:2], 2'b00};
        end

        case (state_q)
            S_IDLE: begin
                if (redirect || (count_q < DEPTH_C)) begin
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                if (mem_ack) begin
                    if (redirect) begin
                        state_d = S_REQ;
                    end else begin
                        fetch_pc_d = fetch_pc_q + 32'd4;
                        // Keep fetching only while the next word has a slot
                        state_d    = (count_d < DEPTH_C) ? S_REQ : S_IDLE;
                    end
                end else if (redirect) begin
                    // The old request must still complete before a new one
                    state_d = S_FLUSH;
                end
            end
            S_FLUSH: begin
                if (mem_ack) begin
                    state_d = S_REQ;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        mem_req_d = (state_d != S_IDLE);

        // An unanswered request keeps its address; otherwise the address
        // follows the fetch pointer so a new request starts from it.
        if (mem_req_q && !mem_ack) begin
            mem_addr_d = mem_addr_q;
        end else begin
            mem_addr_d = fetch_pc_d;
        end
    end

    // ------------------------------------------------------------------------
    // Registered head-of-buffer outputs
    // ------------------------------------------------------------------------
    // The head after this edge is either an entry already stored or, when
    // the buffer drains empty and a word arrives in the same cycle, that
    // arriving word. Either way it is captured in flops, so the outputs have
    // no combinational path from mem_rdata.
    always_comb begin
        inst_valid_d  = 1'b0;
        instruction_d = NOP_INSN;
        inst_pc_d     = 32'h0000_0000;
        if (count_d != '0) begin
            inst_valid_d = 1'b1;
            if (push && (count_after_pop == '0)) begin
                instruction_d = mem_rdata;
                inst_pc_d     = mem_addr_q;
            end else begin
                instruction_d = buf_instr_q[rd_ptr_d];
                inst_pc_d     = buf_pc_q[rd_ptr_d];
            end
        end
    end

    // ------------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            fetch_pc_q    <= RESET_PC;
            mem_req_q     <= 1'b0;
            mem_addr_q    <= RESET_PC;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            inst_valid_q  <= 1'b0;
            instruction_q <= NOP_INSN;
            inst_pc_q     <= 32'h0000_0000;
        end else begin
            state_q       <= state_d;
            fetch_pc_q    <= fetch_pc_d;
            mem_req_q     <= mem_req_d;
            mem_addr_q    <= mem_addr_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            inst_valid_q  <= inst_valid_d;
            instruction_q <= instruction_d;
            inst_pc_q     <= inst_pc_d;
        end
    end

    // Buffer storage needs no reset: entries are only read while counted
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            buf_instr_q[wr_ptr_q] <= mem_rdata;
            buf_pc_q[wr_ptr_q]    <= mem_addr_q;
        end
    end

    assign mem_req     = mem_req_q;
    assign mem_addr    = mem_addr_q;
    assign inst_valid  = inst_valid_q;
    assign instruction = instruction_q;
    assign inst_pc     = inst_pc_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// ============================================================================
// tb_instr_fetch_unit
// ----------------------------------------------------------------------------
// Directed vector table for the reset, handshake, back-pressure and redirect
// sequences, a second instance with RESET_PC at the top of the address space
// to show fetch address wrap, and a randomized run in which the consumed
// instruction stream is compared against a sequential-PC model of the core's
// expected program order.
// ============================================================================
module tb_instr_fetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        inst_ready;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        inst_valid;
    logic [31:0] instruction;
    logic [31:0] inst_pc;

    // Second instance: starts at the last word of the address space
    logic        mem_ack2;
    logic [31:0] mem_rdata2;
    logic        redirect2;
    logic [31:0] redirect_pc2;
    logic        inst_ready2;
    logic        mem_req2;
    logic [31:0] mem_addr2;
    logic        inst_valid2;
    logic [31:0] instruction2;
    logic [31:0] inst_pc2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    instr_fetch_unit #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .inst_valid (inst_valid),
        .instruction(instruction),
        .inst_pc    (inst_pc),
        .inst_ready (inst_ready)
    );

    instr_fetch_unit #(.RESET_PC(32'hFFFF_FFFC), .FIFO_DEPTH(2)) dut_wrap (
        .clk        (clk),
        .rst        (rst),
        .mem_req    (mem_req2),
        .mem_addr   (mem_addr2),
        .mem_ack    (mem_ack2),
        .mem_rdata  (mem_rdata2),
        .redirect   (redirect2),
        .redirect_pc(redirect_pc2),
        .inst_valid (inst_valid2),
        .instruction(instruction2),
        .inst_pc    (inst_pc2),
        .inst_ready (inst_ready2)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Memory contents: a bijective scramble of the address
    function automatic logic [31:0] memf(input logic [31:0] a);
        return {a[7:0], a[31:8]} ^ 32'hA5A5_5A5A;
    endfunction

    typedef struct {
        logic        rst;
        logic        ack;
        logic [31:0] rdata;
        logic        redir;
        logic [31:0] rpc;
        logic        ready;
        logic        chk;    // compare outputs on this row
        logic        req;
        logic        ca;     // compare mem_addr on this row
        logic [31:0] addr;
        logic        valid;
        logic [31:0] instr;
        logic [31:0] pc;
    } vec_t;

    function automatic vec_t v(input logic r, input logic a, input logic [31:0] d,
                               input logic rd, input logic [31:0] rp, input logic rdy,
                               input logic c, input logic q, input logic ca,
                               input logic [31:0] ad, input logic vl,
                               input logic [31:0] ins, input logic [31:0] p);
        vec_t t;
        t.rst = r; t.ack = a; t.rdata = d; t.redir = rd; t.rpc = rp; t.ready = rdy;
        t.chk = c; t.req = q; t.ca = ca; t.addr = ad; t.valid = vl; t.instr = ins; t.pc = p;
        return t;
    endfunction

    vec_t vecs[$];

    initial begin
        // Inputs are driven for the coming edge; expected outputs are those
        // visible during that same cycle (results of earlier edges).
        //                rst ack rdata         rd rpc           rdy  chk req ca addr          vld instr         pc
        vecs.push_back(v(1, 0, 32'h0,         0, 32'h0,        0,   0, 0, 0, 32'h0,        0, NOP,          32'h0));
        vecs.push_back(v(1, 0, 32'h0,         0, 32'h0,        0,   1, 0, 1, 32'h0,        0, NOP,          32'h0));
        vecs.push_back(v(0, 0, 32'h0,         0, 32'h0,        0,   1, 0, 1, 32'h0,        0, NOP,          32'h0));
        vecs.push_back(v(0, 1, 32'h3e800093,  0, 32'h0,        1,   1, 1, 1, 32'h0,        0, NOP,          32'h0));
        vecs.push_back(v(0, 1, 32'h83000113,  0, 32'h0,        1,   1, 1, 1, 32'h4,        1, 32'h3e800093, 32'h0));
        vecs.push_back(v(0, 0, 32'h0,         0, 32'h0,        1,   1, 1, 1, 32'h8,        1, 32'h83000113, 32'h4));
        // Back-pressure: fill the two-entry buffer
        vecs.push_back(v(1, 0, 32'h0,         0, 32'h0,        0,   1, 1, 1, 32'h8,        0, NOP,          32'h0));
        vecs.push_back(v(0, 1, 32'hdeadbeef,  0, 32'h0,        0,   1, 0, 1, 32'h0,        0, NOP,          32'h0));
        vecs.push_back(v(0, 1, 32'h11111111,  0, 32'h0,        0,   1, 1, 1, 32'h0,        0, NOP,          32'h0));
        vecs.push_back(v(0, 1, 32'h22222222,  0, 32'h0,        0,   1, 1, 1, 32'h4,        1, 32'h11111111, 32'h0));
        vecs.push_back(v(0, 1, 32'h33333333,  0, 32'h0,        0,   1, 0, 0, 32'h0,        1, 32'h11111111, 32'h0));
        vecs.push_back(v(0, 0, 32'h0,         0, 32'h0,        1,   1, 0, 0, 32'h0,        1, 32'h11111111, 32'h0));
        vecs.push_back(v(0, 0, 32'h0,         0, 32'h0,        0,   1, 0, 0, 32'h0,        1, 32'h22222222, 32'h4));
        // Redirect while the fetch of 0x8 is pending
        vecs.push_back(v(0, 0, 32'h0,         1, 32'h103,      0,   1, 1, 1, 32'h8,        1, 32'h22222222, 32'h4));
        vecs.push_back(v(0, 0, 32'h0,         0, 32'h0,        0,   1, 1, 1, 32'h8,        0, NOP,          32'h0));
        vecs.push_back(v(0, 1, 32'h3e906193,  0, 32'h0,        1,   1, 1, 1, 32'h8,        0, NOP,          32'h0));
        vecs.push_back(v(0, 0, 32'h0,         0, 32'h0,        1,   1, 1, 1, 32'h100,      0, NOP,          32'h0));
        vecs.push_back(v(0, 1, 32'h44444444,  0, 32'h0,        1,   1, 1, 1, 32'h100,      0, NOP,          32'h0));
        // Redirect together with ack and pop
        vecs.push_back(v(0, 1, 32'h55555555,  1, 32'h200,      1,   1, 1, 1, 32'h104,      1, 32'h44444444, 32'h100));
        vecs.push_back(v(0, 0, 32'h0,         0, 32'h0,        1,   1, 1, 1, 32'h200,      0, NOP,          32'h0));
        // Redirects while flushing, ending at the top word
        vecs.push_back(v(0, 0, 32'h0,         1, 32'hFFFFFFFF, 0,   1, 1, 1, 32'h200,      0, NOP,          32'h0));
        vecs.push_back(v(0, 0, 32'h0,         1, 32'h300,      0,   1, 1, 1, 32'h200,      0, NOP,          32'h0));
        vecs.push_back(v(0, 1, 32'h77777777,  1, 32'hFFFFFFFF, 0,   1, 1, 1, 32'h200,      0, NOP,          32'h0));
        vecs.push_back(v(0, 1, 32'h88888888,  0, 32'h0,        0,   1, 1, 1, 32'hFFFFFFFC, 0, NOP,          32'h0));
        vecs.push_back(v(0, 1, 32'h99999999,  0, 32'h0,        0,   1, 1, 1, 32'h0,        1, 32'h88888888, 32'hFFFFFFFC));
        vecs.push_back(v(0, 0, 32'h0,         0, 32'h0,        0,   1, 0, 0, 32'h0,        1, 32'h88888888, 32'hFFFFFFFC));
        vecs.push_back(v(0, 0, 32'h0,         0, 32'h0,        1,   1, 0, 0, 32'h0,        1, 32'h88888888, 32'hFFFFFFFC));
        vecs.push_back(v(0, 0, 32'h0,         0, 32'h0,        0,   1, 0, 0, 32'h0,        1, 32'h99999999, 32'h0));
        // Reset in the middle of a request with a buffered entry
        vecs.push_back(v(1, 1, 32'habcdabcd,  0, 32'h0,        1,   1, 1, 1, 32'h4,        1, 32'h99999999, 32'h0));
        vecs.push_back(v(0, 1, 32'habcdabcd,  0, 32'h0,        1,   1, 0, 1, 32'h0,        0, NOP,          32'h0));
        vecs.push_back(v(0, 0, 32'h0,         0, 32'h0,        0,   1, 1, 1, 32'h0,        0, NOP,          32'h0));
    end

    // Random-phase model state
    logic [31:0] exp_pc;
    logic        expect_invalid;
    logic        prev_req;
    logic        prev_ack;
    logic [31:0] prev_addr;
    int          consumed;

    initial begin
        rst = 1'b1; mem_ack = 1'b0; mem_rdata = '0; redirect = 1'b0;
        redirect_pc = '0; inst_ready = 1'b0;
        mem_ack2 = 1'b1; mem_rdata2 = 32'h0000_0513; redirect2 = 1'b0;
        redirect_pc2 = '0; inst_ready2 = 1'b1;
        #1;

        // ---------------- directed vector table ----------------
        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            rst         = vecs[i].rst;
            mem_ack     = vecs[i].ack;
            mem_rdata   = vecs[i].rdata;
            redirect    = vecs[i].redir;
            redirect_pc = vecs[i].rpc;
            inst_ready  = vecs[i].ready;
            $display("vec %0d rst=%0b ack=%0b redir=%0b ready=%0b | req=%0b addr=%h valid=%0b instr=%h pc=%h",
                     i, rst, mem_ack, redirect, inst_ready, mem_req, mem_addr, inst_valid, instruction, inst_pc);
            if (vecs[i].chk) begin
                check($sformatf("v%0d_mem_req", i), {31'b0, mem_req}, {31'b0, vecs[i].req});
                if (vecs[i].ca)
                    check($sformatf("v%0d_mem_addr", i), mem_addr, vecs[i].addr);
                check($sformatf("v%0d_inst_valid", i), {31'b0, inst_valid}, {31'b0, vecs[i].valid});
                check($sformatf("v%0d_instruction", i), instruction, vecs[i].instr);
                check($sformatf("v%0d_inst_pc", i), inst_pc, vecs[i].pc);
            end
            // Wrap instance: zero-wait memory, core always ready
            if (i == 2) check("wrap_reset_addr", mem_addr2, 32'hFFFF_FFFC);
            if (i == 3) begin
                check("wrap_req_first", {31'b0, mem_req2}, 32'd1);
                check("wrap_addr_first", mem_addr2, 32'hFFFF_FFFC);
            end
            if (i == 4) begin
                check("wrap_addr_second", mem_addr2, 32'h0000_0000);
                check("wrap_head_pc", inst_pc2, 32'hFFFF_FFFC);
                check("wrap_head_instr", instruction2, 32'h0000_0513);
            end
        end

        // ---------------- randomized run ----------------
        @(negedge clk);
        rst = 1'b1; mem_ack = 1'b0; redirect = 1'b0; inst_ready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        exp_pc = 32'h0; expect_invalid = 1'b0; prev_req = 1'b0; prev_ack = 1'b0;
        prev_addr = '0; consumed = 0;

        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            // Request must hold address until acknowledged
            if (prev_req && !prev_ack) begin
                check("rnd_req_hold", {31'b0, mem_req}, 32'd1);
                check("rnd_addr_hold", mem_addr, prev_addr);
            end
            if (expect_invalid)
                check("rnd_flush_invalid", {31'b0, inst_valid}, 32'd0);
            if (!inst_valid) begin
                check("rnd_idle_instr", instruction, NOP);
                check("rnd_idle_pc", inst_pc, 32'h0);
            end

            mem_ack    = mem_req ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 7) == 0);
            mem_rdata  = memf(mem_addr);
            inst_ready = ($urandom_range(0, 9) < 7);
            redirect   = ($urandom_range(0, 24) == 0);
            if ($urandom_range(0, 3) == 0)
                redirect_pc = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
            else
                redirect_pc = $urandom & 32'h0000_3FFF;

            if (inst_valid && inst_ready && !redirect) begin
                check("rnd_pc", inst_pc, exp_pc);
                check("rnd_instr", instruction, memf(exp_pc));
                $display("consume %0d pc=%h instr=%h", consumed, inst_pc, instruction);
                exp_pc = exp_pc + 32'd4;
                consumed++;
            end
            if (redirect) begin
                exp_pc = {redirect_pc[31:2], 2'b00};
                expect_invalid = 1'b1;
            end else begin
                expect_invalid = 1'b0;
            end
            prev_req  = mem_req;
            prev_ack  = mem_ack;
            prev_addr = mem_addr;
        end

        // The run must have made real forward progress
        check("rnd_progress", {31'b0, (consumed > 300)}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
